// File: rtl/vcmd_enc_if.sv
// vcmd_enc_if: pixel request handshake and command byte stream between producer and encoder
interface vcmd_enc_if;
    logic       PixelValid;
    logic       PixelReady;
    logic [7:0] PixelX;
    logic [7:0] PixelY;
    logic [7:0] PixelData;
    logic [7:0] ByteOut;
    logic       ByteValid;
    logic       ByteReady;
    logic       Busy;
    modport master (
        output PixelValid, PixelX, PixelY, PixelData, ByteReady,
        input  PixelReady, ByteOut, ByteValid, Busy
    );
    modport slave (
        input  PixelValid, PixelX, PixelY, PixelData, ByteReady,
        output PixelReady, ByteOut, ByteValid, Busy
    );
endinterface

// File: rtl/vcmd_enc.sv
// vcmd_enc: serialises pixel writes into SetXY/Write command bytes, tracking the receiver cursor
module vcmd_enc #(
    parameter logic [7:0] RESYNC_EVERY = 8'd0
) (
    input logic        Clk,
    input logic        nReset,
    vcmd_enc_if.slave  bus
);
    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] SEND_CMD_SET = 3'd1;
    localparam logic [2:0] SEND_X       = 3'd2;
    localparam logic [2:0] SEND_Y       = 3'd3;
    localparam logic [2:0] SEND_CMD_WR  = 3'd4;
    localparam logic [2:0] SEND_DATA    = 3'd5;
    logic [2:0] state_q, state_d;
    logic [7:0] x_q, x_d, y_q, y_d, dat_q, dat_d;
    logic [7:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d, run_q, run_d;
    logic       cur_v_q, cur_v_d, rdy_q, rdy_d;
    logic       legal, force_resync, seq, accept, xfer, dxfer, carry;
    always_comb begin
        legal          = state_q <= SEND_DATA;
        bus.ByteValid  = legal && state_q != IDLE;
        bus.ByteOut    = state_q == SEND_CMD_SET ? 8'h11 :
                         state_q == SEND_X       ? x_q   :
                         state_q == SEND_Y       ? y_q   :
                         state_q == SEND_CMD_WR  ? 8'h20 :
                         state_q == SEND_DATA    ? dat_q : 8'h00;
        bus.Busy       = state_q != IDLE;
        bus.PixelReady = rdy_q && state_q == IDLE;
        force_resync   = RESYNC_EVERY != 8'd0 && run_q == RESYNC_EVERY;
        seq            = cur_v_q && bus.PixelX == cur_x_q && bus.PixelY == cur_y_q && !force_resync;
        accept         = bus.PixelValid && bus.PixelReady;
        xfer           = bus.ByteValid && bus.ByteReady;
        dxfer          = xfer && state_q == SEND_DATA;
        // X=255 carries into the receiver's unaddressable gap bit, so the cursor is lost
        carry          = x_q == 8'hff;
        rdy_d          = 1'b1;
        x_d            = accept ? bus.PixelX : x_q;
        y_d            = accept ? bus.PixelY : y_q;
        dat_d          = accept ? bus.PixelData : dat_q;
        run_d          = !accept ? run_q : !seq ? 8'd0 : run_q + {7'd0, run_q != 8'hff};
        state_d        = !legal ? IDLE :
                         accept ? (seq ? SEND_CMD_WR : SEND_CMD_SET) :
                         !xfer  ? state_q :
                         state_q == SEND_DATA ? IDLE : state_q + 3'd1;
        cur_v_d        = dxfer ? !carry : cur_v_q;
        cur_x_d        = dxfer && !carry ? x_q + 8'd1 : cur_x_q;
        cur_y_d        = dxfer && !carry ? y_q : cur_y_q;
    end
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            dat_q   <= 8'd0;
            cur_x_q <= 8'd0;
            cur_y_q <= 8'd0;
            cur_v_q <= 1'b0;
            run_q   <= 8'd0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dat_q   <= dat_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            cur_v_q <= cur_v_d;
            run_q   <= run_d;
            rdy_q   <= rdy_d;
        end
    end
endmodule
